counter_ctrl: RTL

- Sequencing controller for a 4-bit-class free-running up counter.
- Turns the bare counter into a programmable interval timer: start/stop control, programmable terminal value, and one-shot or periodic mode.
- Produces a single-cycle `done` pulse at terminal count.
- Sits between the control/register logic (which drives start, stop, mode and limit) and the logic that consumes the timer event.

---
 rtl/counter_ctrl_pkg.sv | 15 +
 rtl/cnt_datapath.sv | 43 ++++
 rtl/counter_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl interval timer.
package counter_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/cnt_datapath.sv
// Counter register with sync clear/enable, latched terminal value and
// terminal-count compare.
module cnt_datapath
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + WIDTH'(1);
    limit_d = load_i ? limit_i : limit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == limit_q);

endmodule

// File: rtl/counter_ctrl.sv
// Programmable interval timer sequencer: start/stop, one-shot or periodic.
// Optional pause support is built when COUNTER_CTRL_PAUSE_EN is defined.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
`ifdef COUNTER_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   done_q, done_d;
  logic   clr, load, en, term;
  logic   pause_req;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign pause_req = pause;
`else
  assign pause_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop)
          state_d = IDLE;
        else if (start)
          state_d = RUN;
        else if (pause_req)
          state_d = PAUSE;
        else if (term && mode_q == MODE_ONESHOT)
          state_d = IDLE;
      end
      PAUSE: begin
        if (stop)
          state_d = IDLE;
        else if (start || !pause_req)
          state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Terminal check precedes the increment, so the counter never wraps in RUN.
  always_comb begin
    clr    = 1'b0;
    load   = 1'b0;
    en     = 1'b0;
    done_d = 1'b0;
    mode_d = mode_q;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (start && !(state_q == PAUSE && stop)) begin
          clr    = 1'b1;
          load   = 1'b1;
          mode_d = mode;
        end
      end
      RUN: begin
        if (stop) begin
          clr = 1'b0;
        end else if (start) begin
          clr    = 1'b1;
          load   = 1'b1;
          mode_d = mode;
        end else if (pause_req) begin
          en = 1'b0;
        end else if (term) begin
          done_d = 1'b1;
          clr    = (mode_q == MODE_PERIODIC);
        end else begin
          en = 1'b1;
        end
      end
      default: clr = 1'b0;
    endcase
  end

  cnt_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .load_i  (load),
    .en_i    (en),
    .limit_i (limit),
    .count_o (count),
    .term_o  (term)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
